// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that sits beside the data RAM on the MIPS data bus.
// Stores to TXDATA queue bytes in a small FIFO; loads from STATUS return a same-cycle status word.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        TxD,
  output logic        Busy
);

  localparam int                PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DEPTH_C     = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              txd_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_q, count_d;
  logic              ovf_q, ovf_d;

  logic push_req, status_rd, full, empty, pop, push_ok, ovf_evt, baud_last;
  logic unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  assign push_req  = MemWrite && (Address == BASE_ADDR);
  assign status_rd = MemRead && (Address == STATUS_ADDR);
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == 4'd0);
  assign pop       = (state_q == S_IDLE) && !empty;
  // A full FIFO still accepts a store when the transmitter drains an entry on the same edge.
  assign push_ok   = push_req && (!full || pop);
  assign ovf_evt   = push_req && full && !pop;
  assign baud_last = (baud_q == BAUD_LAST);

  assign Hit      = (Address == BASE_ADDR) || (Address == STATUS_ADDR);
  assign Busy     = (state_q != S_IDLE);
  assign TxD      = txd_q;
  assign ReadData = status_rd ? {24'd0, count_q, ovf_q, Busy, empty, full} : 32'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    // A new overflow wins over the clear-on-read of the same edge.
    if (ovf_evt)        ovf_d = 1'b1;
    else if (status_rd) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // TxD is loaded one edge ahead of each state so the pin comes straight off a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (!empty) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= S_START;
            txd_q   <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a byte-queue plus frame-timing model predicts TxD, Busy and STATUS every cycle.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] STAT  = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic        Hit;
  logic        TxD;
  logic        Busy;

  int checks = 0;
  int passed = 0;

  // Model: expected FIFO contents, the frame in flight, and the edge at which the line is free again.
  logic [7:0] exp_q[$];
  int         cyc;
  int         free_edge;
  int         fr_p;
  bit         fr_valid;
  logic [7:0] fr_byte;
  bit         m_ovf;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .ReadData(ReadData),
    .Hit(Hit),
    .TxD(TxD),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic bit m_busy();
    return fr_valid && (cyc >= fr_p) && (cyc < fr_p + FRAME);
  endfunction

  function automatic logic m_txd();
    int seg;
    if (!m_busy()) return 1'b1;
    seg = (cyc - fr_p) / CPB;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return fr_byte[seg-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (exp_q.size() == DEPTH);
    s[1]   = (exp_q.size() == 0);
    s[2]   = m_busy();
    s[3]   = m_ovf;
    s[7:4] = 4'(exp_q.size());
    return s;
  endfunction

  function automatic logic [31:0] m_readdata();
    return (MemRead && Address == STAT) ? m_status() : 32'd0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cyc       = 0;
    free_edge = 0;
    fr_p      = 0;
    fr_valid  = 1'b0;
    fr_byte   = '0;
    m_ovf     = 1'b0;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    MemRead   = re;
    Address   = a;
    WriteData = d;
  endtask

  // Advance one clock edge and apply the same edge to the model using the inputs held across it.
  task automatic tick();
    bit push, srd, do_pop, was_full, ovf_evt;
    @(posedge clk);
    push     = MemWrite && (Address == BASE);
    srd      = MemRead && (Address == STAT);
    cyc      = cyc + 1;
    was_full = (exp_q.size() == DEPTH);
    do_pop   = (exp_q.size() > 0) && (cyc >= free_edge);
    ovf_evt  = 1'b0;
    if (do_pop) begin
      fr_byte   = exp_q.pop_front();
      fr_p      = cyc;
      fr_valid  = 1'b1;
      free_edge = cyc + FRAME + 1;
    end
    if (push) begin
      if (!was_full || do_pop) exp_q.push_back(WriteData[7:0]);
      else ovf_evt = 1'b1;
    end
    if (ovf_evt)  m_ovf = 1'b1;
    else if (srd) m_ovf = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (TxD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", TxD); else passed++;
    checks++;
    if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else passed++;
    drive(1'b0, 1'b1, STAT, 32'd0);
    #1;
    checks++;
    if (ReadData !== 32'h0000_0002) $display("FAIL reset_status: got %h expected 00000002", ReadData); else passed++;
    checks++;
    if (Hit !== 1'b1) $display("FAIL reset_hit: got %b expected 1", Hit); else passed++;
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_single();
    logic [31:0] d;
    d = $urandom;
    drive(1'b1, 1'b0, BASE, d);
    #1;
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < FRAME + 4; i++) begin
      checks++;
      if (TxD !== m_txd()) $display("FAIL single_txd[%0d]: got %b expected %b", i, TxD, m_txd()); else passed++;
      checks++;
      if (Busy !== m_busy()) $display("FAIL single_busy[%0d]: got %b expected %b", i, Busy, m_busy()); else passed++;
      tick();
    end
    drive(1'b0, 1'b1, STAT, 32'd0);
    #1;
    checks++;
    if (ReadData !== 32'h0000_0002) $display("FAIL single_status: got %h expected 00000002", ReadData); else passed++;
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_overflow();
    int   starts;
    logic prev_busy;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, BASE, {$urandom_range(0, 255), 8'(i + 1)} );
      #1;
      tick();
    end
    drive(1'b0, 1'b1, STAT, 32'd0);
    #1;
    checks++;
    if (ReadData !== 32'h0000_004D) $display("FAIL ovf_status: got %h expected 0000004d", ReadData); else passed++;
    checks++;
    if (ReadData !== m_status()) $display("FAIL ovf_status_model: got %h expected %h", ReadData, m_status()); else passed++;
    tick();
    #1;
    checks++;
    if (ReadData !== 32'h0000_0045) $display("FAIL ovf_cleared: got %h expected 00000045", ReadData); else passed++;
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    starts    = 0;
    prev_busy = 1'b1;
    for (int i = 0; i < 5 * (FRAME + 1) + 20; i++) begin
      #1;
      checks++;
      if (TxD !== m_txd()) $display("FAIL ovf_txd[%0d]: got %b expected %b", i, TxD, m_txd()); else passed++;
      checks++;
      if (Busy !== m_busy()) $display("FAIL ovf_busy[%0d]: got %b expected %b", i, Busy, m_busy()); else passed++;
      if (Busy === 1'b1 && prev_busy === 1'b0) starts++;
      prev_busy = Busy;
      tick();
    end
    checks++;
    if (starts !== 4) $display("FAIL ovf_later_frames: got %0d expected 4", starts); else passed++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, BASE, 32'hABCD_EF00);
    #1;
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, BASE, $urandom);
      #1;
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) tick();
    checks++;
    if (TxD !== m_txd()) $display("FAIL mid_pre_txd: got %b expected %b", TxD, m_txd()); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (TxD !== 1'b1) $display("FAIL mid_async_txd: got %b expected 1", TxD); else passed++;
    checks++;
    if (Busy !== 1'b0) $display("FAIL mid_async_busy: got %b expected 0", Busy); else passed++;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, STAT, 32'd0);
    #1;
    checks++;
    if (ReadData !== 32'h0000_0002) $display("FAIL mid_status: got %h expected 00000002", ReadData); else passed++;
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < FRAME + 10; i++) begin
      checks++;
      if (TxD !== 1'b1 || Busy !== 1'b0) $display("FAIL mid_quiet[%0d]: got txd=%b busy=%b expected txd=1 busy=0", i, TxD, Busy); else passed++;
      tick();
    end
  endtask

  task automatic test_decode();
    drive(1'b1, 1'b0, BASE + 32'd8, $urandom);
    #1;
    checks++;
    if (Hit !== 1'b0) $display("FAIL dec_store_far_hit: got %b expected 0", Hit); else passed++;
    tick();
    drive(1'b0, 1'b1, 32'h1001_0000, 32'd0);
    #1;
    checks++;
    if (Hit !== 1'b0) $display("FAIL dec_ram_hit: got %b expected 0", Hit); else passed++;
    checks++;
    if (ReadData !== 32'd0) $display("FAIL dec_ram_rd: got %h expected 00000000", ReadData); else passed++;
    tick();
    drive(1'b0, 1'b1, BASE, 32'd0);
    #1;
    checks++;
    if (Hit !== 1'b1) $display("FAIL dec_txdata_hit: got %b expected 1", Hit); else passed++;
    checks++;
    if (ReadData !== 32'd0) $display("FAIL dec_txdata_rd: got %h expected 00000000", ReadData); else passed++;
    tick();
    drive(1'b1, 1'b0, STAT, $urandom);
    #1;
    tick();
    drive(1'b0, 1'b0, STAT, 32'd0);
    #1;
    checks++;
    if (ReadData !== 32'd0) $display("FAIL dec_noread_rd: got %h expected 00000000", ReadData); else passed++;
    drive(1'b0, 1'b1, STAT, 32'd0);
    #1;
    checks++;
    if (ReadData !== 32'h0000_0002) $display("FAIL dec_status_after: got %h expected 00000002", ReadData); else passed++;
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (TxD !== 1'b1 || Busy !== 1'b0) $display("FAIL dec_quiet[%0d]: got txd=%b busy=%b expected txd=1 busy=0", i, TxD, Busy); else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int          r;
    logic [31:0] a;
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3, 4: drive(1'b1, 1'b0, BASE, $urandom);
        5, 6:          drive(1'b0, 1'b1, STAT, 32'd0);
        7:             drive(1'b1, 1'b0, STAT, $urandom);
        8: begin
          a = ($urandom_range(0, 1) == 0) ? BASE + 32'd8 : $urandom;
          drive(1'b1, 1'b0, a, $urandom);
        end
        9: begin
          a = ($urandom_range(0, 1) == 0) ? 32'h1001_0000 : $urandom;
          drive(1'b0, 1'b1, a, 32'd0);
        end
        default: drive(1'b0, 1'b0, 32'd0, 32'd0);
      endcase
      #1;
      checks++;
      if (ReadData !== m_readdata()) $display("FAIL rnd_rd[%0d]: got %h expected %h", i, ReadData, m_readdata()); else passed++;
      checks++;
      if (Hit !== (Address == BASE || Address == STAT)) $display("FAIL rnd_hit[%0d]: got %b expected %b", i, Hit, (Address == BASE || Address == STAT)); else passed++;
      checks++;
      if (TxD !== m_txd()) $display("FAIL rnd_txd[%0d]: got %b expected %b", i, TxD, m_txd()); else passed++;
      checks++;
      if (Busy !== m_busy()) $display("FAIL rnd_busy[%0d]: got %b expected %b", i, Busy, m_busy()); else passed++;
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_overflow();
    test_reset_mid();
    test_decode();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
